// File: rtl/player_mover_n_if.sv
// rtl/player_mover_n_if.sv - joystick/sprite-side bundle for player_mover_n
interface player_mover_n_if #(
  parameter int NPLAYERS = 2,
  parameter int PW       = 11,
  parameter int SPW      = 8
);
  logic                    eof;
  logic [NPLAYERS*PW-1:0]  init_x;
  logic [NPLAYERS*PW-1:0]  init_y;
  logic [NPLAYERS-1:0]     key_up;
  logic [NPLAYERS-1:0]     key_down;
  logic [NPLAYERS-1:0]     key_left;
  logic [NPLAYERS-1:0]     key_right;
  logic [NPLAYERS*SPW-1:0] speed;
  logic [NPLAYERS*PW-1:0]  pos_x;
  logic [NPLAYERS*PW-1:0]  pos_y;
  logic [NPLAYERS*3-1:0]   sprite;
  logic [NPLAYERS-1:0]     moving;
  logic                    frame_done;

  modport master (
    output eof, init_x, init_y, key_up, key_down, key_left, key_right, speed,
    input  pos_x, pos_y, sprite, moving, frame_done
  );

  modport slave (
    input  eof, init_x, init_y, key_up, key_down, key_left, key_right, speed,
    output pos_x, pos_y, sprite, moving, frame_done
  );
endinterface

// File: rtl/player_mover_n.sv
// rtl/player_mover_n.sv - frame-stepped tile movement controller for NPLAYERS players
// Optional macro PLAYER_ANIM_EN adds a per-player walk-animation toggle.
module player_mover_n #(
  parameter int NPLAYERS = 2,
  parameter int TILE     = 32,
  parameter int GRID_W   = 25,
  parameter int GRID_H   = 17,
  parameter int PW       = 11,
  parameter int FRAC     = 4,
  parameter int SPW      = 8,
  parameter int ANIM_DIV = 8
) (
  input  logic            clk,
  input  logic            reset,
  player_mover_n_if.slave bus
);
  localparam int QW = PW + FRAC;
  localparam int IW = (NPLAYERS > 1) ? $clog2(NPLAYERS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NPLAYERS - 1);
  localparam logic signed [PW-1:0] TILE_S = PW'(TILE);
  localparam logic signed [PW-1:0] MAX_X = PW'((GRID_W - 1) * TILE);
  localparam logic signed [PW-1:0] MAX_Y = PW'((GRID_H - 1) * TILE);
  localparam logic [2:0] SPR_FACE   = 3'd0;
  localparam logic [2:0] SPR_UP1    = 3'd1;
  localparam logic [2:0] SPR_RIGHT1 = 3'd3;
  localparam logic [2:0] SPR_LEFT1  = 3'd5;

  typedef logic signed [QW-1:0] q_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_RIGHT, DIR_LEFT} dir_t;
  typedef enum logic [1:0] {S_IDLE, S_LOOK, S_STEP} state_t;

  state_t          state, state_next;
  logic [IW-1:0]   idx, idx_next;
  logic            frame_done_next;
  logic            frame_done_r;

  q_t                   px    [NPLAYERS];
  q_t                   py    [NPLAYERS];
  q_t                   delta [NPLAYERS];
  logic signed [PW-1:0] goal  [NPLAYERS];
  dir_t                 dir   [NPLAYERS];
  logic                 mv    [NPLAYERS];
  logic [2:0]           spr   [NPLAYERS];

  function automatic logic [2:0] frame1(input dir_t d);
    case (d)
      DIR_UP:    return SPR_UP1;
      DIR_RIGHT: return SPR_RIGHT1;
      DIR_LEFT:  return SPR_LEFT1;
      default:   return SPR_FACE;
    endcase
  endfunction

`ifdef PLAYER_ANIM_EN
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [AW-1:0] ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [2:0] SPR_UP2    = 3'd2;
  localparam logic [2:0] SPR_RIGHT2 = 3'd4;
  localparam logic [2:0] SPR_LEFT2  = 3'd6;

  logic [AW-1:0] anim_cnt [NPLAYERS];

  // Down has no second walk frame, so it stays on FACE.
  function automatic logic [2:0] frame2(input dir_t d);
    case (d)
      DIR_UP:    return SPR_UP2;
      DIR_RIGHT: return SPR_RIGHT2;
      DIR_LEFT:  return SPR_LEFT2;
      default:   return SPR_FACE;
    endcase
  endfunction
`endif

  // Move-start decode for the player under the index.
  logic                 key_any, start;
  dir_t                 sel_dir;
  logic [SPW-1:0]       spd;
  q_t                   spd_q, new_delta;
  logic signed [PW-1:0] tile_x, tile_y, new_goal;

  always_comb begin
    spd      = bus.speed[int'(idx) * SPW +: SPW];
    spd_q    = $signed({{(QW - SPW){1'b0}}, spd});
    tile_x   = px[idx][QW-1:FRAC];
    tile_y   = py[idx][QW-1:FRAC];
    key_any  = bus.key_up[idx] | bus.key_down[idx] | bus.key_right[idx] | bus.key_left[idx];
    sel_dir  = DIR_LEFT;
    if (bus.key_up[idx])
      sel_dir = DIR_UP;
    else if (bus.key_down[idx])
      sel_dir = DIR_DOWN;
    else if (bus.key_right[idx])
      sel_dir = DIR_RIGHT;
    start = !mv[idx] && key_any && (spd != '0);
    case (sel_dir)
      DIR_UP: begin
        new_goal  = tile_y - TILE_S;
        new_delta = -spd_q;
      end
      DIR_DOWN: begin
        new_goal  = tile_y + TILE_S;
        new_delta = spd_q;
      end
      DIR_RIGHT: begin
        new_goal  = tile_x + TILE_S;
        new_delta = spd_q;
      end
      default: begin
        new_goal  = tile_x - TILE_S;
        new_delta = -spd_q;
      end
    endcase
  end

  // Step evaluation on the moving axis; off-map goals land on the opposite edge tile.
  logic                 vert, wrap, arrive;
  logic signed [PW-1:0] max_a;
  q_t                   cur_a, next_a, goal_q, land;

  always_comb begin
    vert   = (dir[idx] == DIR_UP) || (dir[idx] == DIR_DOWN);
    cur_a  = vert ? py[idx] : px[idx];
    max_a  = vert ? MAX_Y : MAX_X;
    next_a = cur_a + delta[idx];
    goal_q = {goal[idx], {FRAC{1'b0}}};
    wrap   = (goal[idx] < 0) || (goal[idx] > max_a);
    arrive = delta[idx][QW-1] ? (next_a <= goal_q) : (next_a >= goal_q);
    if (!wrap)
      land = goal_q;
    else if (goal[idx] < 0)
      land = {max_a, {FRAC{1'b0}}};
    else
      land = '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
    end
  end

  always_comb begin
    state_next      = state;
    idx_next        = idx;
    frame_done_next = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.eof) begin
          state_next = S_LOOK;
          idx_next   = '0;
        end
      end
      S_LOOK: begin
        if (mv[idx] || start) begin
          state_next = S_STEP;
        end else if (idx == LAST) begin
          state_next      = S_IDLE;
          idx_next        = '0;
          frame_done_next = 1'b1;
        end else begin
          idx_next = idx + IW'(1);
        end
      end
      S_STEP: begin
        if (idx == LAST) begin
          state_next      = S_IDLE;
          idx_next        = '0;
          frame_done_next = 1'b1;
        end else begin
          state_next = S_LOOK;
          idx_next   = idx + IW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_done_r <= 1'b0;
      for (int i = 0; i < NPLAYERS; i++) begin
        px[i]    <= {bus.init_x[i*PW +: PW], {FRAC{1'b0}}};
        py[i]    <= {bus.init_y[i*PW +: PW], {FRAC{1'b0}}};
        delta[i] <= '0;
        goal[i]  <= '0;
        dir[i]   <= DIR_DOWN;
        mv[i]    <= 1'b0;
        spr[i]   <= SPR_FACE;
`ifdef PLAYER_ANIM_EN
        anim_cnt[i] <= '0;
`endif
      end
    end else begin
      frame_done_r <= frame_done_next;
      if (state == S_LOOK && start) begin
        mv[idx]    <= 1'b1;
        goal[idx]  <= new_goal;
        delta[idx] <= new_delta;
        dir[idx]   <= sel_dir;
        spr[idx]   <= frame1(sel_dir);
`ifdef PLAYER_ANIM_EN
        anim_cnt[idx] <= '0;
`endif
      end
      if (state == S_STEP) begin
        if (wrap || arrive) begin
          if (vert)
            py[idx] <= land;
          else
            px[idx] <= land;
          mv[idx]  <= 1'b0;
          spr[idx] <= frame1(dir[idx]);
        end else begin
          if (vert)
            py[idx] <= next_a;
          else
            px[idx] <= next_a;
`ifdef PLAYER_ANIM_EN
          if (anim_cnt[idx] == ANIM_LAST) begin
            anim_cnt[idx] <= '0;
            spr[idx]      <= (spr[idx] == frame1(dir[idx])) ? frame2(dir[idx]) : frame1(dir[idx]);
          end else begin
            anim_cnt[idx] <= anim_cnt[idx] + 1'b1;
          end
`endif
        end
      end
    end
  end

  assign bus.frame_done = frame_done_r;

  for (genvar i = 0; i < NPLAYERS; i++) begin : g_out
    assign bus.pos_x[i*PW +: PW] = px[i][QW-1:FRAC];
    assign bus.pos_y[i*PW +: PW] = py[i][QW-1:FRAC];
    assign bus.sprite[i*3 +: 3]  = spr[i];
    assign bus.moving[i]         = mv[i];
  end
endmodule

// File: tb/tb_player_mover_n.sv
// tb/tb_player_mover_n.sv - scoreboard bench for player_mover_n
module tb_player_mover_n;
  localparam int NP  = 2;
  localparam int PW  = 11;
  localparam int SPW = 8;
  localparam logic [2:0] S_FACE = 3'd0, S_UP1 = 3'd1, S_RIGHT1 = 3'd3, S_LEFT1 = 3'd5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  player_mover_n_if #(.NPLAYERS(NP), .PW(PW), .SPW(SPW)) bus ();

  player_mover_n #(
    .NPLAYERS(NP), .TILE(32), .GRID_W(25), .GRID_H(17),
    .PW(PW), .FRAC(4), .SPW(SPW), .ANIM_DIV(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef struct {
    int               id;
    int               lat;
    logic [NP*PW-1:0] x;
    logic [NP*PW-1:0] y;
    logic [NP*3-1:0]  s;
    logic [NP-1:0]    m;
  } exp_t;

  exp_t frame_q[$];
  exp_t now_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic cmp(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s id=%0d actual=%0h required=%0h", name, id, act, req);
    end
  endtask

  // Monitor: frame records pop on frame_done, snapshot records on the next falling edge.
  exp_t e;
  int   lat_cnt = 0;
  logic busy    = 1'b0;

  always @(negedge clk) begin
    while (now_q.size() > 0) begin
      e = now_q.pop_front();
      cmp("snap_pos_x", e.id, 32'(bus.pos_x), 32'(e.x));
      cmp("snap_pos_y", e.id, 32'(bus.pos_y), 32'(e.y));
      cmp("snap_sprite", e.id, 32'(bus.sprite), 32'(e.s));
      cmp("snap_moving", e.id, 32'(bus.moving), 32'(e.m));
      cmp("snap_frame_done", e.id, 32'(bus.frame_done), 32'd0);
    end
    if (reset) begin
      busy = 1'b0;
    end else begin
      if (busy)
        lat_cnt++;
      else if (bus.eof) begin
        busy    = 1'b1;
        lat_cnt = 0;
      end
      if (bus.frame_done) begin
        if (frame_q.size() == 0) begin
          cmp("unexpected_frame_done", -1, 32'(bus.frame_done), 32'd0);
        end else begin
          e = frame_q.pop_front();
          cmp("pos_x", e.id, 32'(bus.pos_x), 32'(e.x));
          cmp("pos_y", e.id, 32'(bus.pos_y), 32'(e.y));
          cmp("sprite", e.id, 32'(bus.sprite), 32'(e.s));
          cmp("moving", e.id, 32'(bus.moving), 32'(e.m));
          if (e.lat >= 0)
            cmp("latency", e.id, 32'(lat_cnt), 32'(e.lat));
          else
            cmp("latency_bound", e.id, 32'(lat_cnt <= 5), 32'd1);
        end
        busy = 1'b0;
      end
    end
  end

  function automatic logic [NP*PW-1:0] pk(input int a0, input int a1);
    logic [PW-1:0] v0, v1;
    v0 = PW'(a0);
    v1 = PW'(a1);
    return {v1, v0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic keys(input logic [NP-1:0] u, input logic [NP-1:0] d, input logic [NP-1:0] r, input logic [NP-1:0] l);
    bus.key_up    = u;
    bus.key_down  = d;
    bus.key_right = r;
    bus.key_left  = l;
  endtask

  task automatic do_reset(input int id, input int x0, input int y0, input int x1, input int y1);
    exp_t r;
    bus.init_x = pk(x0, x1);
    bus.init_y = pk(y0, y1);
    bus.eof    = 1'b0;
    keys('0, '0, '0, '0);
    reset = 1'b1;
    tick();
    tick();
    r.id = id; r.lat = -1; r.x = pk(x0, x1); r.y = pk(y0, y1); r.s = '0; r.m = '0;
    now_q.push_back(r);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic run_frame(input int id, input int lat, input logic [NP*PW-1:0] x, input logic [NP*PW-1:0] y,
                           input logic [NP*3-1:0] s, input logic [NP-1:0] m, input logic dbl);
    exp_t r;
    logic got;
    r.id = id; r.lat = lat; r.x = x; r.y = y; r.s = s; r.m = m;
    frame_q.push_back(r);
    bus.eof = 1'b1;
    got     = 1'b0;
    for (int n = 1; n <= 40 && !got; n++) begin
      tick();
      if (n == 1) bus.eof = 1'b0;
      if (dbl && n == 2) bus.eof = 1'b1;
      if (dbl && n == 3) bus.eof = 1'b0;
      if (bus.frame_done) got = 1'b1;
    end
    if (!got) begin
      $display("FAIL frame_timeout id=%0d actual=no_frame_done required=frame_done", id);
      $fatal(1);
    end
    keys('0, '0, '0, '0);
    repeat (8) tick();
  endtask

  initial begin
    reset = 1'b1;
    bus.speed = '0;

    // Up at 1 px/frame and right at 3 px/frame, together; second eof ignored.
    do_reset(100, 128, 128, 448, 448);
    bus.speed = {8'd48, 8'd16};
    for (int f = 1; f <= 33; f++) begin
      int y0, x1, lat;
      if (f == 1) keys(2'b01, 2'b00, 2'b10, 2'b00);
      y0  = (f < 32) ? 128 - f : 96;
      x1  = (f < 11) ? 448 + 3 * f : 480;
      lat = (f == 1) ? 5 : ((f == 33) ? 3 : -1);
      run_frame(f, lat, pk(128, x1), pk(y0, 448), {S_RIGHT1, S_UP1},
                {logic'(f < 11), logic'(f < 32)}, f == 1);
    end

    // Wrap-around, up-over-left priority, zero speed.
    do_reset(200, 0, 64, 64, 512);
    bus.speed = {8'd16, 8'd16};
    keys(2'b00, 2'b10, 2'b00, 2'b01);
    run_frame(201, 5, pk(768, 64), pk(64, 0), {S_FACE, S_LEFT1}, 2'b00, 1'b0);
    bus.speed = {8'd0, 8'd16};
    keys(2'b01, 2'b00, 2'b10, 2'b01);
    run_frame(202, 4, pk(768, 64), pk(63, 0), {S_FACE, S_UP1}, 2'b01, 1'b0);
    run_frame(203, 4, pk(768, 64), pk(62, 0), {S_FACE, S_UP1}, 2'b01, 1'b0);

    // Reset in the middle of a frame while pos_y = 110.
    do_reset(300, 128, 128, 448, 448);
    bus.speed = {8'd0, 8'd16};
    for (int f = 1; f <= 18; f++) begin
      if (f == 1) keys(2'b01, 2'b00, 2'b00, 2'b00);
      run_frame(300 + f, -1, pk(128, 448), pk(128 - f, 448), {S_FACE, S_UP1}, 2'b01, 1'b0);
    end
    bus.eof = 1'b1;
    tick();
    bus.eof = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    begin
      exp_t r;
      r.id = 399; r.lat = -1; r.x = pk(128, 448); r.y = pk(128, 448); r.s = '0; r.m = '0;
      now_q.push_back(r);
    end
    reset = 1'b0;
    repeat (12) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/player_mover_n.md
Name: player_mover_n

Overview:
Parametrised successor of the two-player movement controller. Moves NPLAYERS players tile-by-tile on a GRID_W x GRID_H tile map, in fixed-point steps once per video frame. Handles screen-edge wrap-around and drives each player's sprite index. Sits between the joystick decoder and the sprite renderer and is triggered by the frame EOF strobe.

Parameters:
NPLAYERS, 2, number of players (1..8)
TILE, 32, tile size in pixels (power of two)
GRID_W, 25, map width in tiles
GRID_H, 17, map height in tiles
PW, 11, signed pixel coordinate width
FRAC, 4, fractional bits of internal position
SPW, 8, speed field width, in units of 1/2^FRAC pixel per frame
ANIM_DIV, 8, frames per animation toggle (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  synchronous reset, active-high
eof  in  1  end-of-frame strobe
init_x  in  NPLAYERS*PW  reset X of each player in pixels, slice i = player i
init_y  in  NPLAYERS*PW  reset Y of each player
key_up / key_down / key_left / key_right  in  NPLAYERS each  per-player direction keys
speed  in  NPLAYERS*SPW  per-player speed
pos_x  out  NPLAYERS*PW  player X in pixels (integer part)
pos_y  out  NPLAYERS*PW  player Y in pixels
sprite  out  NPLAYERS*3  sprite index: FACE=0 UP1=1 UP2=2 RIGHT1=3 RIGHT2=4 LEFT1=5 LEFT2=6
moving  out  NPLAYERS  1 while the player is between tiles
frame_done  out  1  one-cycle pulse when all players have been updated

Behaviour:
- Reset: clocked on clk, sync, active-high; reset wins over everything, including mid-frame processing.
- Values under reset: pos_x/pos_y = init_x/init_y, fraction = 0; moving = 0; sprite = FACE; frame_done = 0; FSM = IDLE; player index = 0.
- FSM IDLE: if eof = 1, go to LOOK with index 0. eof seen outside IDLE is ignored; no queuing.
- LOOK (1 cycle):
  - If the player is WAITING, keys are checked with priority up > down > right > left.
  - goal = current tile position +/- TILE on the chosen axis. delta = +/- speed, sampled at move start and fixed for the whole move.
  - moving := 1; sprite := UP1 / FACE / RIGHT1 / LEFT1.
  - If no key is pressed or speed = 0, the player stays WAITING and the FSM skips STEP.
- STEP (1 cycle), only for MOVING players:
  - next = pos + delta at PW+FRAC width, signed.
  - If next reaches or passes goal (>= for positive delta, <= for negative): pos := {goal, FRAC zeros}; moving := 0; sprite := FACE if the last direction was down, else the direction's frame-1 index.
  - Otherwise pos := next.
- Wrap-around:
  - If goal is < 0 or > (GRID_W-1)*TILE, or the equivalent on Y with GRID_H, the move completes in a single STEP.
  - pos is set to the opposite edge tile (0 or (GRID_W-1)*TILE); moving := 0 in that STEP.
- After each player: index increments. After index NPLAYERS-1, frame_done pulses for 1 cycle and the FSM returns to IDLE.
- Latency: at most 2*NPLAYERS+1 cycles from eof to frame_done.
- A new move starts only at the LOOK of the frame after arrival, so a move always lasts at least one full frame.
- Positions are always tile-aligned while WAITING. Off-axis coordinate is never modified.
- Outputs are registered; pos_x/pos_y change only in STEP or under reset.

Optional Feature:
PLAYER_ANIM_EN
- Defined: a per-player frame counter runs while moving. Every ANIM_DIV processed frames, sprite toggles between frame 1 and frame 2 of the current direction (UP1<->UP2 etc.). Down toggles FACE<->UP1 is not used; down stays FACE. The counter clears at move start.
- Undefined: sprite stays at frame 1 (or FACE) for the whole move, and no counter logic is generated.

Test Plan:
- Player 0 at (128,128), speed=16, key_up held for one frame -> pos_y reaches 127..96 over 32 frames; moving=0 and pos_y=96 at frame 32; sprite=UP1 afterwards.
- Player 1 at (448,448), speed=48, key_right -> X steps 451,454,...,478 for 10 frames; 11th frame snaps to 480; moving=0.
- key_up and key_left pressed together -> only Y changes (priority up); sprite=UP1.
- Player at X=0 presses left -> in that frame's STEP pos_x=768 ((25-1)*32); moving=0 after 1 frame. Player at Y=512 presses down -> pos_y=0.
- eof pulsed again 2 cycles after the first eof with NPLAYERS=2 -> ignored; exactly one frame_done, 5 cycles after the first eof.
- reset asserted mid-move (pos_y=110) -> next cycle pos = init values, moving=0, sprite=FACE, no frame_done.
